// File: rtl/memory_access_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_ctrl_pkg
//  Description : Shared types and constants for the memory access controller:
//                access state encoding, requester ids, timer width.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    // Access sequencer states (2-bit encoding)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    // Requester ids used by the round-robin "last served" bit
    localparam logic c_req_fetch = 1'b0;
    localparam logic c_req_data  = 1'b1;

    // Width of the access timeout counter (TIMEOUT is limited to 1..255)
    localparam int c_timer_w = 8;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/memory_access_controller_access_timer.sv
`default_nettype none
// ============================================================================
//  Module      : access_timer
//  Description : Clear/enable counter that flags expiry once TIMEOUT-1 stall
//                cycles have been counted in the current access.
//  Revision    : 1.0  initial release
// ============================================================================
module access_timer
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [c_timer_w-1:0] c_limit = c_timer_w'(TIMEOUT - 1);

    logic [c_timer_w-1:0] r_count;

    // Stall counter: cleared on grant, advances on each access cycle without ready
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + c_timer_w'(1);
        end
    end

    assign o_expire = (r_count == c_limit);

endmodule : access_timer
`default_nettype wire

// File: rtl/memory_access_controller.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_controller
//  Description : Arbitrates the single memory port between instruction fetch
//                and data load/store, runs the memory handshake, drives the
//                MDR / IR load enables and aborts accesses that stall too long.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 FetchReq,
    input  logic [ADDR_SIZE-1:0] FetchAddr,
    output logic                 FetchDone,
    input  logic                 DataReq,
    input  logic                 DataWrite,
    input  logic [ADDR_SIZE-1:0] DataAddr,
    input  logic [DATA_SIZE-1:0] DataWData,
    output logic                 DataDone,
    output logic [ADDR_SIZE-1:0] MemAddr,
    output logic [DATA_SIZE-1:0] MemWData,
    output logic                 MemRead,
    output logic                 MemWrite,
    input  logic                 MemReady,
    output logic                 MdrEnable,
    output logic                 IrEnable,
    output logic                 BusError,
    output logic                 Busy
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_last;
    logic [ADDR_SIZE-1:0]   r_mem_addr;
    logic [DATA_SIZE-1:0]   r_mem_wdata;
    logic                   r_mem_read;
    logic                   r_mem_write;
    logic                   r_fetch_done;
    logic                   r_data_done;
    logic                   r_bus_error;

    logic                   w_grant;
    logic                   w_pick_fetch;
    logic                   w_in_access;
    logic                   w_finish;
    logic                   w_timeout;
    logic                   w_expire;

    access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_access_timer (
        .Clk      (Clk),
        .Rst      (Rst),
        .i_clear  (w_grant),
        .i_enable (w_in_access & ~MemReady),
        .o_expire (w_expire)
    );

    // Next-state, arbitration and same-cycle load enables
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_pick_fetch = 1'b0;
        w_in_access  = (r_state != S_IDLE);
        // Ready on the expiry cycle is a normal completion, not a timeout
        w_timeout    = w_in_access & ~MemReady & w_expire;
        w_finish     = w_in_access & (MemReady | w_expire);
        MdrEnable    = (r_state == S_LOAD)  & MemReady;
        IrEnable     = (r_state == S_FETCH) & MemReady;
        Busy         = w_in_access;

        case (r_state)
            S_IDLE: begin
                // A Done pulse in flight blocks regrant so the requester can drop Req
                if ((FetchReq | DataReq) & ~r_fetch_done & ~r_data_done) begin
                    w_grant      = 1'b1;
                    w_pick_fetch = FetchReq & (~DataReq | (r_last == c_req_data));
                    if (w_pick_fetch) begin
                        w_state_next = S_FETCH;
                    end else if (DataWrite) begin
                        w_state_next = S_STORE;
                    end else begin
                        w_state_next = S_LOAD;
                    end
                end
            end
            default: begin
                if (w_finish) begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Memory-side registers, round-robin bit and completion pulses
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_last       <= c_req_data;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_fetch_done <= w_finish & (r_state == S_FETCH);
            r_data_done  <= w_finish & ((r_state == S_LOAD) | (r_state == S_STORE));
            r_bus_error  <= w_timeout;
            if (w_grant) begin
                r_last      <= w_pick_fetch ? c_req_fetch : c_req_data;
                r_mem_addr  <= w_pick_fetch ? FetchAddr : DataAddr;
                r_mem_read  <= w_pick_fetch | ~DataWrite;
                r_mem_write <= ~w_pick_fetch & DataWrite;
                if (~w_pick_fetch & DataWrite) begin
                    r_mem_wdata <= DataWData;
                end
            end else if (w_finish) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end
        end
    end

    assign MemAddr   = r_mem_addr;
    assign MemWData  = r_mem_wdata;
    assign MemRead   = r_mem_read;
    assign MemWrite  = r_mem_write;
    assign FetchDone = r_fetch_done;
    assign DataDone  = r_data_done;
    assign BusError  = r_bus_error;

endmodule : memory_access_controller
`default_nettype wire

// File: tb/tb_memory_access_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_access_controller
//  Description : Self-checking bench for memory_access_controller with an
//                access-level reference model, directed scenarios and
//                randomized requester/memory traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_access_controller;

    localparam int TO = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        FetchReq = 1'b0;
    logic [31:0] FetchAddr = '0;
    logic        FetchDone;
    logic        DataReq = 1'b0;
    logic        DataWrite = 1'b0;
    logic [31:0] DataAddr = '0;
    logic [31:0] DataWData = '0;
    logic        DataDone;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemRead;
    logic        MemWrite;
    logic        MemReady = 1'b0;
    logic        MdrEnable;
    logic        IrEnable;
    logic        BusError;
    logic        Busy;

    logic [31:0] MemRData = '0;
    logic [31:0] mdr = '0;

    int checks   = 0;
    int failures = 0;

    // Reference model: one outstanding access described by kind/age
    bit          m_active;
    int          m_kind;        // 0 fetch, 1 load, 2 store
    int          m_age;         // access cycles spent so far, first cycle = 1
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_last_data;
    bit          m_fdone;
    bit          m_ddone;
    bit          m_berr;

    memory_access_controller #(
        .ADDR_SIZE (32),
        .DATA_SIZE (32),
        .TIMEOUT   (TO)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .FetchReq  (FetchReq),
        .FetchAddr (FetchAddr),
        .FetchDone (FetchDone),
        .DataReq   (DataReq),
        .DataWrite (DataWrite),
        .DataAddr  (DataAddr),
        .DataWData (DataWData),
        .DataDone  (DataDone),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemReady  (MemReady),
        .MdrEnable (MdrEnable),
        .IrEnable  (IrEnable),
        .BusError  (BusError),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    // Stand-in MemoryDataRegister
    always @(posedge Clk) if (MdrEnable) mdr <= MemRData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit nf, nd, nb, pf;
        nf = 0; nd = 0; nb = 0; pf = 0;
        if (!Rst) begin
            m_active = 0; m_kind = 0; m_age = 0; m_addr = '0; m_wdata = '0;
            m_fdone = 0; m_ddone = 0; m_berr = 0; m_last_data = 1;
        end else begin
            if (m_active) begin
                if (MemReady || m_age == TO) begin
                    m_active = 0;
                    if (m_kind == 0) nf = 1; else nd = 1;
                    nb = !MemReady;
                end else begin
                    m_age++;
                end
            end else if ((FetchReq || DataReq) && !m_fdone && !m_ddone) begin
                pf = FetchReq && (!DataReq || m_last_data);
                m_active    = 1;
                m_age       = 1;
                m_last_data = !pf;
                if (pf) begin
                    m_kind = 0;
                    m_addr = FetchAddr;
                end else begin
                    m_kind = DataWrite ? 2 : 1;
                    m_addr = DataAddr;
                    if (DataWrite) m_wdata = DataWData;
                end
            end
            m_fdone = nf; m_ddone = nd; m_berr = nb;
        end
    endtask

    task automatic model_check();
        chk("busy",     Busy,      m_active);
        chk("memread",  MemRead,   m_active && m_kind != 2);
        chk("memwrite", MemWrite,  m_active && m_kind == 2);
        chk("memaddr",  MemAddr,   m_addr);
        chk("memwdata", MemWData,  m_wdata);
        chk("irenable", IrEnable,  m_active && m_kind == 0 && MemReady);
        chk("mdrenable",MdrEnable, m_active && m_kind == 1 && MemReady);
        chk("fetchdone",FetchDone, m_fdone);
        chk("datadone", DataDone,  m_ddone);
        chk("buserror", BusError,  m_berr);
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge
    task automatic step();
        @(negedge Clk);
        model_check();
        @(posedge Clk);
        model_update();
        #1;
    endtask

    // Single request with a given number of stall cycles, checked explicitly
    task automatic access(input bit f, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input int waits, input logic [31:0] rd);
        bit st, ld;
        st = !f && w;
        ld = !f && !w;
        if (f) begin FetchReq = 1; FetchAddr = a; end
        else begin DataReq = 1; DataWrite = w; DataAddr = a; DataWData = d; end
        MemReady = 0;
        step();
        for (int i = 0; i < waits && i < TO; i++) begin
            MemReady = 0;
            #1;
            chk("acc_addr",  MemAddr, a);
            chk("acc_read",  MemRead, !st);
            chk("acc_write", MemWrite, st);
            if (st) chk("acc_wdata", MemWData, d);
            chk("acc_mdr_en", MdrEnable, 1'b0);
            step();
        end
        if (waits < TO) begin
            MemReady = 1;
            MemRData = rd;
            #1;
            chk("acc_ir_en",  IrEnable,  f);
            chk("acc_mdr_en", MdrEnable, ld);
            step();
        end
        FetchReq = 0; DataReq = 0; MemReady = 0;
        #1;
        chk("acc_done", f ? FetchDone : DataDone, 1'b1);
        chk("acc_berr", BusError, waits >= TO);
        if (ld && waits < TO) chk("acc_mdr", mdr, rd);
        step();
    endtask

    initial begin
        bit [2:0] order_exp;
        int       n;
        order_exp = 3'b101;
        n = 0;

        // Reset from power-up
        repeat (2) @(posedge Clk);
        model_update();
        #1;
        Rst = 1;
        chk("rst_busy", Busy, 1'b0);
        chk("rst_addr", MemAddr, 32'h0);
        step();

        // Reset asserted mid-LOAD: aborts with no Done
        DataReq = 1; DataWrite = 0; DataAddr = 32'h80; MemReady = 0;
        step(); step();
        Rst = 0;
        step(); step();
        DataReq = 0; Rst = 1;
        #1;
        chk("midrst_busy", Busy, 1'b0);
        chk("midrst_read", MemRead, 1'b0);
        chk("midrst_done", DataDone, 1'b0);
        chk("midrst_berr", BusError, 1'b0);
        step(); step();

        // Load with 3 wait cycles, ready on the TIMEOUT-th access cycle
        access(0, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        // Store
        access(0, 1, 32'h40, 32'h1234, 2, 32'h0);
        // Zero-wait fetch
        access(1, 0, 32'h200, 32'h0, 0, 32'h0);
        // Timeout on a load, then fetch ready exactly at TIMEOUT
        access(0, 0, 32'h300, 32'h0, TO + 2, 32'h0);
        access(1, 0, 32'h304, 32'h0, TO - 1, 32'h0);
        step();

        // Tie from reset with both held: fetch, data, fetch
        Rst = 0; FetchReq = 1; DataReq = 1; DataWrite = 0;
        FetchAddr = 32'h10; DataAddr = 32'h20; MemReady = 1;
        step(); step();
        Rst = 1;
        for (int i = 0; i < 9; i++) begin
            #1;
            if ((IrEnable || MdrEnable) && n < 3) begin
                chk("tie_order", IrEnable, order_exp[n]);
                n++;
            end
            step();
        end
        chk("tie_count", n, 3);
        FetchReq = 0; DataReq = 0; MemReady = 0;
        step(); step();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (FetchReq && m_fdone) FetchReq = 0;
            else if (!FetchReq && $urandom_range(0, 3) == 0) begin
                FetchReq = 1; FetchAddr = $urandom;
            end
            if (DataReq && m_ddone) DataReq = 0;
            else if (!DataReq && $urandom_range(0, 3) == 0) begin
                DataReq = 1; DataWrite = $urandom_range(0, 1) == 1;
                DataAddr = $urandom; DataWData = $urandom;
            end
            MemReady = ($urandom_range(0, 2) == 0);
            MemRData = $urandom;
            Rst = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_memory_access_controller
`default_nettype wire
